// File: rtl/ldpc_pkg.sv
// Decoder-wide constants and helpers shared by the check-node and variable-node sides
// of the min-sum LDPC decoder.
package ldpc_pkg;

    localparam int DEC_W      = 6;
    localparam int DEC_WC     = 4;
    localparam int DEC_OFS    = 1;
    localparam int DEC_NROWS  = 8;
    localparam int EDGE_IDX_W = 2;

    // Zero magnitude maps to +0 whatever the sign, so no negative zero escapes.
    function automatic logic [DEC_W-1:0] sm_to_tc(input logic neg, input logic [DEC_W-2:0] mag);
        logic [DEC_W-1:0] ext;
        ext = {1'b0, mag};
        return (neg && (|mag)) ? -ext : ext;
    endfunction

endpackage

// File: rtl/cnu_edge_out.sv
// One check-to-variable edge: offset subtraction floored at zero, then
// sign-magnitude to two's complement.
module cnu_edge_out
    import ldpc_pkg::*;
#(
    parameter int W   = DEC_W,
    parameter int OFS = DEC_OFS
) (
    input  logic [W-2:0] mag,
    input  logic         sg,
    output logic [W-1:0] y
);

    localparam logic [W-2:0] OFS_M = (W-1)'(OFS);

    logic [W-2:0] m;

    always_comb begin
        m = (mag > OFS_M) ? (mag - OFS_M) : '0;
        y = sm_to_tc(sg, m);
    end

endmodule

// File: rtl/cnu_msg_gen.sv
// Check-node output stage: expands (min1, min2, index, signs) into four
// offset-corrected messages through a two-stage valid/ready pipeline with a row tag.
module cnu_msg_gen
    import ldpc_pkg::*;
#(
    parameter int W     = DEC_W,
    parameter int Wc    = DEC_WC,
    parameter int OFS   = DEC_OFS,
    parameter int NROWS = DEC_NROWS,
    parameter int RW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-2:0]      min1,
    input  logic [W-2:0]      min2,
    input  logic [1:0]        q1q0,
    input  logic [Wc-1:0]     sgn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Wc*W-1:0]   y,
    output logic [RW-1:0]     out_row,
    output logic              out_last
);

    logic                  s1_valid;
    logic [Wc-1:0][W-2:0]  s1_mag;
    logic [Wc-1:0]         s1_sg;
    logic [Wc*W-1:0]       y_next;
    logic [RW-1:0]         row;
    logic                  s2_adv;

    // Stage 2 frees up when empty or draining, so in_ready follows out_ready combinationally.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        in_ready = !s1_valid || s2_adv;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_sg    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < Wc; i++) begin
                    s1_mag[i] <= (q1q0 == EDGE_IDX_W'(i)) ? min2 : min1;
                end
                s1_sg <= {Wc{^sgn}} ^ sgn;
            end
        end
    end

    for (genvar g = 0; g < Wc; g++) begin : g_edge
        cnu_edge_out #(
            .W   (W),
            .OFS (OFS)
        ) u_edge (
            .mag (s1_mag[g]),
            .sg  (s1_sg[g]),
            .y   (y_next[W*g +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y <= y_next;
            end
        end
    end

    // Row tag advances only on an output handshake, so stalls and bubbles leave it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row <= '0;
        end else if (out_valid && out_ready) begin
            row <= (row == RW'(NROWS-1)) ? '0 : row + 1'b1;
        end
    end

    always_comb begin
        out_row  = row;
        out_last = out_valid && (row == RW'(NROWS-1));
    end

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Self-checking bench for cnu_msg_gen: per-scenario tasks plus an input-side
// scoreboard that predicts every output beat from an independent model.
module tb_cnu_msg_gen;

    localparam int W = 6;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  min1;
    logic [4:0]  min2;
    logic [1:0]  q1q0;
    logic [3:0]  sgn;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] y;
    logic [2:0]  out_row;
    logic        out_last;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_in   = 0;
    int n_out  = 0;
    int n_last = 0;
    int cyc    = 0;
    int exp_row = 0;
    logic [23:0] sb[$];

    cnu_msg_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .min1      (min1),
        .min2      (min2),
        .q1q0      (q1q0),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: each edge gets the min over the other three edges, sign = XOR of the other signs.
    function automatic logic [23:0] model(input logic [4:0] a, input logic [4:0] b,
                                          input logic [1:0] q, input logic [3:0] s);
        logic [23:0] r;
        int mag, m, v;
        bit neg;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            mag = (int'(q) == i) ? int'(b) : int'(a);
            m   = (mag > 1) ? mag - 1 : 0;
            neg = 1'b0;
            for (int j = 0; j < 4; j++) if (j != i) neg ^= s[j];
            v = neg ? -m : m;
            r[i*6 +: 6] = v[5:0];
        end
        return r;
    endfunction

    // Handshakes are sampled on the falling edge, where inputs are settled for the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            exp_row = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL sb_unexpected: beat y=%h row=%0d with no beat expected", y, out_row);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    if (y !== e || out_row !== 3'(exp_row) || out_last !== (exp_row == 7)) begin
                        n_fail++;
                        $display("[TB] FAIL sb_beat: got y=%h row=%0d last=%b, want y=%h row=%0d last=%b",
                                 y, out_row, out_last, e, exp_row, (exp_row == 7));
                    end
                end
                if (out_last) n_last++;
                exp_row = (exp_row + 1) % 8;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(min1, min2, q1q0, sgn));
                n_in++;
            end
        end
    end

    task automatic send(input logic [4:0] a, input logic [4:0] b,
                        input logic [1:0] q, input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        min1 = a; min2 = b; q1q0 = q; sgn = s;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL send_timeout: in_ready=%b, want 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_basic();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || y !== '0 || out_row !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got v=%b y=%h row=%0d last=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, y, out_row, out_last, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(5'd3, 5'd7, 2'd2, 4'b0101);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL latency_early: out_valid=%b one cycle after accept, want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || y !== {6'b000010, 6'b111010, 6'b000010, 6'b111110} || out_row !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL basic_beat: got v=%b y=%h row=%0d, want v=1 y=%h row=0",
                     out_valid, y, out_row, {6'b000010, 6'b111010, 6'b000010, 6'b111110});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_offset_floor();
        logic [23:0] want [2];
        want[0] = '0;
        want[1] = {6'b100010, 6'b100010, 6'b100010, 6'b011110};
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bit seen;
            if (k == 0) send(5'd1, 5'd0, 2'd0, 4'b1111);
            else        send(5'd31, 5'd31, 2'd0, 4'b0001);
            seen = 1'b0;
            for (int t = 0; t < 5 && !seen; t++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    n_cmp++;
                    if (y !== want[k]) begin
                        n_fail++;
                        $display("[TB] FAIL offset_floor_%0d: got y=%h, want y=%h", k, y, want[k]);
                    end
                end
            end
            if (!seen) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL offset_floor_%0d_timeout: out_valid=0, want 1", k);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] held;
        int out0;
        out0 = n_out;
        out_ready = 1'b0;
        send(5'd2, 5'd9, 2'd0, 4'b0011);
        send(5'd4, 5'd5, 2'd1, 4'b1000);
        min1 = 5'd6; min2 = 5'd20; q1q0 = 2'd3; sgn = 4'b0110;
        in_valid = 1'b1;
        @(negedge clk);
        held = y;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_full: got in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (y !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_hold: got y=%h v=%b rdy=%b, want y=%h v=1 rdy=0", y, out_valid, in_ready, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(5'd6, 5'd20, 2'd3, 4'b0110);
        send(5'd0, 5'd1, 2'd2, 4'b1011);
        send(5'd15, 5'd16, 2'd1, 4'b0100);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_out - out0 !== 5 || sb.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got %0d beats out, %0d pending, want 5 and 0", n_out - out0, sb.size());
        end
    endtask

    task automatic test_back_to_back_row_wrap();
        int out0, last0, c0;
        do_reset();
        out_ready = 1'b1;
        out0 = n_out;
        last0 = n_last;
        c0 = cyc;
        for (int k = 0; k < 9; k++) begin
            send(5'(k + 1), 5'(k + 3), 2'(k), 4'(k * 5));
        end
        n_cmp++;
        if (cyc - c0 !== 9) begin
            n_fail++;
            $display("[TB] FAIL throughput: 9 beats took %0d cycles, want 9", cyc - c0);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_out - out0 !== 9 || n_last - last0 !== 1) begin
            n_fail++;
            $display("[TB] FAIL row_wrap: got %0d beats %0d last, want 9 beats 1 last", n_out - out0, n_last - last0);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        out_ready = 1'b0;
        send(5'd5, 5'd8, 2'd1, 4'b1001);
        send(5'd7, 5'd9, 2'd0, 4'b0111);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_row !== 3'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got v=%b row=%0d rdy=%b, want 0 0 1", out_valid, out_row, in_ready);
        end
        @(posedge clk);
        #1;
        send(5'd10, 5'd12, 2'd3, 4'b1110);
        seen = 1'b0;
        for (int t = 0; t < 5 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (out_row !== 3'd0) begin
                    n_fail++;
                    $display("[TB] FAIL post_reset_row: got row=%0d, want 0", out_row);
                end
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL post_reset_timeout: out_valid=0, want 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int in0, out0;
        in0 = n_in;
        out0 = n_out;
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            min1 = 5'($urandom_range(0, 31));
            min2 = 5'($urandom_range(0, 31));
            q1q0 = 2'($urandom_range(0, 3));
            sgn  = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_in - in0 !== n_out - out0 || sb.size() !== 0) begin
            n_fail++;
            $display("[TB] FAIL random_count: got %0d in %0d out %0d pending, want equal and 0",
                     n_in - in0, n_out - out0, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        min1 = '0;
        min2 = '0;
        q1q0 = '0;
        sgn = '0;
        @(posedge clk);
        #1;
        test_reset_basic();
        test_offset_floor();
        test_backpressure();
        test_back_to_back_row_wrap();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cnu_msg_gen.md
Name: cnu_msg_gen

Overview:
- Check-node output stage of the min-sum LDPC decoder.
- Consumes the compressed check-node result (min1, min2, 2-bit index of min1) from the 4-input min finder, plus the four edge sign bits aligned with it.
- Regenerates four offset-corrected, two's-complement check-to-variable messages.
- Two-stage valid/ready pipeline with a row counter that tags each output with its check-node row.

Parameters:
- W, 6, message width in two's complement; magnitudes are W-1 bits.
- Wc, 4, check-node degree; only 4 is supported, since the index is 2 bits.
- OFS, 1, offset subtracted from each magnitude (offset min-sum).
- NROWS, 8, number of check-node rows per iteration; row counter modulus.
- RW, 3, row counter width; must satisfy 2^RW >= NROWS.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-low (rst==0 resets on the clock edge)
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- min1  in  W-1  smallest edge magnitude
- min2  in  W-1  second-smallest edge magnitude
- q1q0  in  2  edge index (0..3) holding min1
- sgn  in  Wc  edge sign bits; 1 = negative; bit i belongs to edge i
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- y  out  Wc*W  messages; edge i at y[W*(i+1)-1:W*i], two's complement
- out_row  out  RW  row index of the beat on y
- out_last  out  1  out_valid && out_row==NROWS-1

Behaviour:
- Reset (rst==0 at posedge):
  - Clears both stage valids, all data registers and the row counter.
  - Values after reset: out_valid=0, y=0, out_row=0, out_last=0.
  - in_ready=1 from the first cycle after reset.
  - A beat in flight is discarded, with no partial output.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A beat leaves when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, y, out_row and out_valid are held stable.
- Pipeline:
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv. in_ready is combinational from out_ready; there are no internal combinational loops.
- Stage 1 (on accept):
  - ts = XOR of sgn[3:0].
  - mag_i = (q1q0==i) ? min2 : min1.
  - sg_i = ts ^ sgn[i].
  - Register mag_i, sg_i and s1_valid.
- Stage 2 (when s2_adv):
  - m_i = (mag_i > OFS) ? mag_i - OFS : 0, with no underflow.
  - y_i = sg_i ? -m_i : m_i, in W-bit two's complement; m_i==0 gives y_i=0 regardless of sign (no negative zero).
  - out_valid <= s1_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from accept to out_valid when unstalled.
  - Throughput is 1 beat/cycle.
- Row counter:
  - Increments on each output handshake; wraps NROWS-1 -> 0.
  - out_row is the counter value while out_valid=1.
  - Counter is not advanced by stalls or idle cycles.
- Edge conditions:
  - min1==min2: both magnitudes are equal; the index still selects min2 for edge q1q0.
  - min1=0: non-min edges output 0.
  - Max magnitude 2^(W-1)-1: the negated value -(2^(W-1)-1) fits in W bits, so no overflow.
  - Simultaneous accept and output handshake in the same cycle: both proceed, and the pipeline stays full.
  - out_ready low for N cycles with in_valid high: at most 2 beats are buffered, then in_ready=0; no beat is lost or duplicated.

Decomposition:
- Shared package (ldpc_pkg) holds:
  - W, Wc, OFS, NROWS as decoder-wide constants.
  - An edge index width constant (2).
  - A function for sign-magnitude -> two's complement, shared with the variable-node side.
- One natural sub-module, cnu_edge_out: a single edge's offset + saturate + sign conversion. It is instantiated Wc times in stage 2.

Test Plan:
1. Reset then basic: rst=0 for 2 clk, then min1=3, min2=7, q1q0=2, sgn=4'b0101, out_ready=1.
   - Two cycles later, edges 0..3 = -2, +2, -6, +2, i.e. 6'b111110, 000010, 111010, 000010.
   - out_row=0.
2. Offset floor: min1=1, min2=0, q1q0=0, sgn=4'b1111.
   - All edges give y=0, with no negative zero.
   - Then min1=31, min2=31, sgn=4'b0001: edge0=+30; edges 1..3=-30 (6'b100010).
3. Backpressure: stream 5 beats with out_ready=0 for cycles 2..6.
   - in_ready drops after 2 buffered beats.
   - y is held stable while stalled.
   - After release, all 5 beats emerge in order, once each.
4. Row wrap: 9 consecutive beats, NROWS=8.
   - out_row sequence is 0..7, 0.
   - out_last=1 only on the 8th beat.
5. Reset mid-stream: reset asserted while 2 beats are in flight.
   - Next cycle out_valid=0 and out_row=0.
   - The first beat after reset appears with out_row=0.
6. Random streams against a reference model, with random in_valid/out_ready.
   - Every output equals the model.
   - Beat count in equals beat count out.
